// File: rtl/alu_uart_interface.sv
// rtl/alu_uart_interface.sv - UART byte sequencer feeding an ALU (A, B, op) and returning its result
// Optional ALU_IF_FLAGS_BYTE_EN: transmit a second byte {overflow, zero} after the result.
module alu_uart_interface #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_alu_overflow,
    input  logic               i_alu_zero,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op_code,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic               o_busy
);

`ifdef ALU_IF_FLAGS_BYTE_EN
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, SEND_RES, WAIT_RES, SEND_FLG, WAIT_FLG
    } state_t;
`else
    typedef enum logic [2:0] {
        WAIT_A, WAIT_B, WAIT_OP, SEND_RES, WAIT_RES
    } state_t;
`endif

    state_t             r_state;
    state_t             w_next_state;
    logic [NB_DATA-1:0] r_data_a;
    logic [NB_DATA-1:0] r_data_b;
    logic [NB_OP-1:0]   r_op_code;
    logic [NB_DATA-1:0] r_tx_data;
    logic               r_tx_start;

`ifdef ALU_IF_FLAGS_BYTE_EN
    logic [1:0]         r_flags;
`else
    logic               w_unused_flags;
    assign w_unused_flags = i_alu_overflow ^ i_alu_zero;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // tx_done takes priority simply because rx_done is not looked at in the wait-for-tx states
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_A:   if (i_rx_done) w_next_state = WAIT_B;
            WAIT_B:   if (i_rx_done) w_next_state = WAIT_OP;
            WAIT_OP:  if (i_rx_done) w_next_state = SEND_RES;
            SEND_RES: w_next_state = WAIT_RES;
`ifdef ALU_IF_FLAGS_BYTE_EN
            WAIT_RES: if (i_tx_done) w_next_state = SEND_FLG;
            SEND_FLG: w_next_state = WAIT_FLG;
            WAIT_FLG: if (i_tx_done) w_next_state = WAIT_A;
`else
            WAIT_RES: if (i_tx_done) w_next_state = WAIT_A;
`endif
            default:  w_next_state = WAIT_A;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_a   <= '0;
            r_data_b   <= '0;
            r_op_code  <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
`ifdef ALU_IF_FLAGS_BYTE_EN
            r_flags    <= 2'b00;
`endif
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                WAIT_A:  if (i_rx_done) r_data_a <= i_rx_data;
                WAIT_B:  if (i_rx_done) r_data_b <= i_rx_data;
                WAIT_OP: if (i_rx_done) r_op_code <= i_rx_data[NB_OP-1:0];
                SEND_RES: begin
                    r_tx_data  <= i_alu_result;
                    r_tx_start <= 1'b1;
`ifdef ALU_IF_FLAGS_BYTE_EN
                    r_flags    <= {i_alu_overflow, i_alu_zero};
`endif
                end
`ifdef ALU_IF_FLAGS_BYTE_EN
                SEND_FLG: begin
                    r_tx_data  <= {{(NB_DATA-2){1'b0}}, r_flags};
                    r_tx_start <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign o_data_a   = r_data_a;
    assign o_data_b   = r_data_b;
    assign o_op_code  = r_op_code;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_busy     = !(r_state == WAIT_A || r_state == WAIT_B || r_state == WAIT_OP);

endmodule
